// File: rtl/range_sum_engine.sv
// range_sum_engine: pipelined per-channel accumulator of K-scaled arithmetic range sums.
// Define RANGE_SUM_OVF_DET_EN to add the sticky per-channel ovf output.
module range_sum_engine #(
  parameter int W = 32,
  parameter int ACC_W = 64,
  parameter int NUM_CH = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [W-1:0]            in_mlo,
  input  logic [W-1:0]            in_mhi,
  input  logic [W-1:0]            in_k,
  input  logic                    in_neg,
  input  logic [CH_W-1:0]         in_ch,
  output logic [NUM_CH*ACC_W-1:0] sum,
  output logic                    done,
  output logic                    busy,
  output logic [31:0]             entry_count
`ifdef RANGE_SUM_OVF_DET_EN
  ,
  output logic [NUM_CH-1:0]       ovf
`endif
);
  localparam int PW = 3*W+1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic v, last, neg;
    logic [CH_W-1:0] ch;
    logic [W-1:0] k;
    logic [W:0] s, n;
  } st1_t;
  typedef struct packed {
    logic v, last, neg;
    logic [CH_W-1:0] ch;
    logic [W-1:0] k;
    logic [2*W:0] h;
  } st2_t;
  typedef struct packed {
    logic v, last;
    logic [CH_W-1:0] ch;
    logic [ACC_W-1:0] t;
  } st3_t;
  state_t state_q, state_d;
  st1_t st1_q, st1_d;
  st2_t st2_q, st2_d;
  st3_t st3_q, st3_d;
  logic [NUM_CH-1:0][ACC_W-1:0] sum_q, sum_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2*W+1:0] p;
  logic [PW-1:0] prod;
  logic [ACC_W-1:0] mag;
  logic accept, clear;
  assign in_ready = state_q == RUN;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign accept = in_valid && in_ready;
  assign clear = start && (state_q == IDLE || state_q == DONE);
  assign sum = sum_q;
  assign entry_count = cnt_q;
`ifdef RANGE_SUM_OVF_DET_EN
  localparam int EW = (PW > ACC_W) ? PW : ACC_W+1;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic tr_q, tr_d;
  logic [EW-1:0] prod_x;
  assign ovf = ovf_q;
`endif
  always_comb begin
    st1_d = '{v: accept, last: in_last, neg: in_neg, ch: in_ch, k: in_k,
              s: {1'b0, in_mlo} + {1'b0, in_mhi},
              n: (in_mhi >= in_mlo) ? {1'b0, in_mhi - in_mlo} + (W+1)'(1) : '0};
    // (m_lo+m_hi)*len is always even, so the halving is exact
    p = (2*W+2)'(st1_q.s) * (2*W+2)'(st1_q.n);
    st2_d = '{v: st1_q.v, last: st1_q.last, neg: st1_q.neg, ch: st1_q.ch, k: st1_q.k,
              h: (2*W+1)'(p >> 1)};
    prod = PW'(st2_q.h) * PW'(st2_q.k);
    mag = ACC_W'(prod);
    st3_d = '{v: st2_q.v, last: st2_q.last, ch: st2_q.ch, t: st2_q.neg ? -mag : mag};
    sum_d = sum_q;
`ifdef RANGE_SUM_OVF_DET_EN
    prod_x = EW'(prod);
    tr_d = |(prod_x >> ACC_W);
    ovf_d = ovf_q;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (st3_q.v && st3_q.ch == CH_W'(c)) begin
        sum_d[c] = sum_q[c] + st3_q.t;
`ifdef RANGE_SUM_OVF_DET_EN
        ovf_d[c] = ovf_q[c] | tr_q | (sum_q[c][ACC_W-1] == st3_q.t[ACC_W-1] &&
                                      sum_d[c][ACC_W-1] != sum_q[c][ACC_W-1]);
`endif
      end
    end
    if (clear) sum_d = '0;
`ifdef RANGE_SUM_OVF_DET_EN
    if (clear) ovf_d = '0;
`endif
    cnt_d = clear ? '0 : cnt_q + 32'(accept);
    state_d = clear ? RUN :
              (state_q == RUN && accept && in_last) ? DRAIN :
              (state_q == DRAIN && st3_q.v && st3_q.last) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st1_q <= '0;
      st2_q <= '0;
      st3_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
`ifdef RANGE_SUM_OVF_DET_EN
      ovf_q <= '0;
      tr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      st1_q <= st1_d;
      st2_q <= st2_d;
      st3_q <= st3_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
`ifdef RANGE_SUM_OVF_DET_EN
      ovf_q <= ovf_d;
      tr_q <= tr_d;
`endif
    end
  end
endmodule

// File: tb/tb_range_sum_engine.sv
// tb_range_sum_engine: table-driven and randomized checks of range_sum_engine against an arithmetic model.
module tb_range_sum_engine;
  localparam int NC = 3;
  logic clk = 0, rst, start, in_valid, in_last, in_neg, in_ready, done, busy;
  logic [31:0] in_mlo, in_mhi, in_k, entry_count;
  logic [1:0] in_ch;
  logic [NC*64-1:0] sum;
`ifdef RANGE_SUM_OVF_DET_EN
  logic [NC-1:0] ovf;
`endif
  always #5 clk = ~clk;
  range_sum_engine #(.W(32), .ACC_W(64), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_mlo(in_mlo), .in_mhi(in_mhi), .in_k(in_k), .in_neg(in_neg),
    .in_ch(in_ch), .sum(sum), .done(done), .busy(busy), .entry_count(entry_count)
`ifdef RANGE_SUM_OVF_DET_EN
    , .ovf(ovf)
`endif
  );
  typedef struct {
    logic [31:0] lo, hi, k;
    logic neg;
    logic [1:0] ch;
    logic [63:0] exp;
  } vec_t;
  vec_t jq[$];
  vec_t tbl[6];
  logic [63:0] zs [3];
  int n_cmp = 0, n_fail = 0;
  function automatic logic [63:0] contrib(logic [31:0] lo, logic [31:0] hi, logic [31:0] k, logic neg);
    logic [127:0] v = '0;
    if (hi >= lo) v = (128'(lo) + 128'(hi)) * (128'(hi) - 128'(lo) + 128'd1) / 128'd2 * 128'(k);
    return neg ? -v[63:0] : v[63:0];
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_sums(input string nm, input logic [63:0] es [3]);
    for (int c = 0; c < NC; c++) check($sformatf("%s_sum%0d", nm, c), sum[c*64 +: 64], es[c]);
  endtask
  task automatic pulse_start();
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
  endtask
  task automatic drive(input vec_t e, input logic last);
    in_mlo = e.lo; in_mhi = e.hi; in_k = e.k; in_neg = e.neg; in_ch = e.ch;
    in_last = last; in_valid = 1;
  endtask
  task automatic send(input vec_t e, input logic last);
    drive(e, last);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic run_job(input int gap, input string nm);
    logic [63:0] es [3];
    int lat;
    es = '{default: '0};
    foreach (jq[i]) if (jq[i].ch < NC) es[jq[i].ch] += jq[i].exp;
    pulse_start();
    foreach (jq[i]) begin
      while ($urandom_range(99) < gap) begin
        in_valid = 0;
        @(posedge clk);
        @(negedge clk);
      end
      send(jq[i], i == jq.size() - 1);
    end
    lat = 1;
    check({nm, "_ready_after_last"}, 64'(in_ready), 0);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_done_latency"}, 64'(lat), 4);
    check_sums(nm, es);
    check({nm, "_count"}, 64'(entry_count), 64'(jq.size()));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1; start = 0; in_valid = 0; in_last = 0; in_neg = 0;
    in_mlo = 0; in_mhi = 0; in_k = 0; in_ch = 0;
    zs = '{default: '0};
    tbl[0] = '{32'd1, 32'd10, 32'd11, 1'b0, 2'd0, 64'd605};
    tbl[1] = '{32'd2, 32'd3, 32'd101, 1'b1, 2'd0, -64'd505};
    tbl[2] = '{32'd5, 32'd4, 32'd7, 1'b0, 2'd1, 64'd0};
    tbl[3] = '{32'd1, 32'd9, 32'd1111, 1'b0, 2'd1, 64'd49995};
    tbl[4] = '{32'd3, 32'd3, 32'd7, 1'b0, 2'd2, 64'd21};
    tbl[5] = '{32'd1, 32'd10, 32'd11, 1'b0, 2'd3, 64'd605};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_sums("reset", zs);
    check("reset_done", 64'(done), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_ready", 64'(in_ready), 0);
    check("reset_count", 64'(entry_count), 0);
    rst = 1; start = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0; start = 0;
    check("rst_over_start_busy", 64'(busy), 0);
    check("rst_over_start_ready", 64'(in_ready), 0);
    pulse_start();
    check("single_ready", 64'(in_ready), 1);
    send(tbl[0], 1);
    check("single_ready_after", 64'(in_ready), 0);
    check("single_busy", 64'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    check("single_sum_early", sum[63:0], 0);
    check("single_done_early", 64'(done), 0);
    @(negedge clk);
    check("single_sum", sum[63:0], 605);
    check("single_done", 64'(done), 1);
    check("single_count", 64'(entry_count), 1);
    check("single_busy_done", 64'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      jq = '{tbl[i]};
      run_job(0, $sformatf("tbl%0d", i));
    end
    jq = '{tbl[0], tbl[1], tbl[2], tbl[3]};
    run_job(0, "b2b");
    check("b2b_sum0_const", sum[63:0], 64'd100);
    check("b2b_sum1_const", sum[127:64], 64'd49995);
    start = 1;
    @(posedge clk);
    @(negedge clk);
    check("restart_busy", 64'(busy), 1);
    check("restart_ready", 64'(in_ready), 1);
    check("restart_sum1", sum[127:64], 0);
    check("restart_count", 64'(entry_count), 0);
    @(posedge clk);
    @(negedge clk);
    start = 0;
    check("held_start_busy", 64'(busy), 1);
    send(tbl[0], 0);
    pulse_start();
    send(tbl[3], 1);
    repeat (3) @(negedge clk);
    check("run_start_done", 64'(done), 1);
    check("run_start_sum0", sum[63:0], 605);
    check("run_start_sum1", sum[127:64], 49995);
    check("run_start_count", 64'(entry_count), 2);
    pulse_start();
    send(tbl[0], 0);
    send(tbl[3], 1);
    check("drain_busy", 64'(busy), 1);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_sums("drain_rst", zs);
    check("drain_rst_done", 64'(done), 0);
    check("drain_rst_busy", 64'(busy), 0);
    check("drain_rst_count", 64'(entry_count), 0);
    repeat (4) @(negedge clk);
    check_sums("drain_rst_later", zs);
    jq = '{tbl[1], tbl[2]};
    run_job(30, "post_rst");
    jq.delete();
    for (int i = 0; i < 468; i++) begin
      vec_t e;
      int mode = $urandom_range(3);
      e.lo = $urandom;
      e.hi = mode == 0 ? $urandom : mode == 1 ? e.lo + $urandom_range(1000) :
             mode == 2 ? e.lo - $urandom_range(1, 50) : e.lo;
      if (mode == 3) begin
        e.lo = $urandom_range(100);
        e.hi = $urandom_range(100);
      end
      e.k = $urandom;
      e.neg = 1'($urandom_range(1));
      e.ch = 2'($urandom_range(3));
      e.exp = contrib(e.lo, e.hi, e.k, e.neg);
      jq.push_back(e);
    end
    run_job(25, "rand");
`ifdef RANGE_SUM_OVF_DET_EN
    jq = '{'{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'd0,
             contrib(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0)}};
    run_job(0, "ovf_job");
    check("ovf_set", 64'(ovf[0]), 1);
    check("ovf_other", 64'(ovf[1]), 0);
    pulse_start();
    check("ovf_cleared", 64'(ovf[0]), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/range_sum_engine.md
RANGE_SUM_ENGINE -- requirements
Module: range_sum_engine

Interface
REQ-001 SHALL have parameter W, default 32: unsigned width of m_lo, m_hi and K operands.
REQ-002 SHALL have parameter ACC_W, default 64: width of each per-channel accumulator.
REQ-003 SHALL have parameter NUM_CH, default 2, range 1..8: number of independent accumulator channels; CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have ports: clk in 1, rising-edge clock. Reset is rst, synchronous, active-high; clock is clk.
REQ-005 SHALL have ports: rst in 1 reset; start in 1 clear-and-run pulse; in_valid in 1; in_ready out 1; in_last in 1, final entry of the job.
REQ-006 SHALL have ports: in_mlo in W; in_mhi in W; in_k in W; in_neg in 1, subtract contribution; in_ch in CH_W, target channel.
REQ-007 SHALL have ports: sum out NUM_CH*ACC_W, channel c at bits [c*ACC_W +: ACC_W]; done out 1; busy out 1; entry_count out 32; ovf out NUM_CH (macro only).

Function
REQ-008 SHALL compute per entry: contribution = K*(m_lo+m_hi)*(m_hi-m_lo+1)/2 if m_hi >= m_lo, else 0.
REQ-009 SHALL negate the contribution when in_neg=1 and add it, two's complement, to accumulator in_ch; arithmetic wraps modulo 2^ACC_W.
REQ-010 SHALL compute with no intermediate truncation: s = m_lo+m_hi (W+1 bits); n (W+1 bits); p = s*n (2W+2 bits); h = p>>1, which is exact because p is always even; h*K (3W+1 bits), truncated to ACC_W only at accumulation.
REQ-011 SHALL transfer an entry exactly on a rising edge where in_valid && in_ready.
REQ-012 SHALL pipeline the datapath as 4 register stages (sum/len/empty, multiply, scale by K, accumulate): the contribution SHALL be reflected in sum exactly 4 cycles after the acceptance edge.
REQ-013 SHALL sustain one accepted entry per cycle in RUN with no bubbles.
REQ-014 SHALL route entries with in_ch >= NUM_CH through the pipeline, counted, contributing 0.
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE; in_ready=1 only in RUN; busy=1 in RUN and DRAIN.
REQ-016 SHALL transition IDLE->RUN on start: clear all sums, entry_count and ovf on that edge.
REQ-017 SHALL transition RUN->DRAIN on acceptance of an entry with in_last=1.
REQ-018 SHALL transition DRAIN->DONE on the edge where the last entry's contribution enters its accumulator; done=1 from that cycle onward.
REQ-019 SHALL hold sum and done in DONE until start, which re-clears and enters RUN.
REQ-020 SHALL ignore start in RUN and DRAIN.
REQ-021 SHALL increment entry_count (wrapping at 2^32) on every acceptance.

Reset
REQ-022 SHALL on rst force state IDLE, pipeline valid bits 0, sum 0, entry_count 0, done 0, busy 0, in_ready 0, ovf 0, regardless of state; in-flight entries are discarded.
REQ-023 SHALL give rst priority over start when both are asserted on the same edge.

Configuration
REQ-024 SHALL, with RANGE_SUM_OVF_DET_EN defined, set sticky ovf[c] when an accumulation into channel c overflows signed ACC_W, or when truncation of h*K to ACC_W discards nonzero bits; ovf[c] is cleared by start or rst.
REQ-025 SHALL, without RANGE_SUM_OVF_DET_EN, omit ovf port and logic entirely; sums wrap silently.

Verification
REQ-026 SHALL cover: start; one entry m_lo=1, m_hi=10, K=11, ch0, last -> sum[0]=605 exactly 4 cycles after acceptance, done=1, entry_count=1.
REQ-027 SHALL cover: entries (1,10,11,+,ch0), (2,3,101,-,ch0), (5,4,7,+,ch1, empty), (1,9,1111,+,ch1, last) back-to-back -> sum[0]=100, sum[1]=49995, entry_count=4.
REQ-028 SHALL cover: random in_valid gaps over 468 entries -> sums equal the reference model; in_ready=0 after last; done 4 cycles after last acceptance.
REQ-029 SHALL cover: rst asserted during DRAIN -> next cycle state IDLE, sum=0, done=0; a subsequent job is unaffected by discarded entries.
REQ-030 SHALL cover, with RANGE_SUM_OVF_DET_EN and ACC_W=64: K=2^32-1, m_lo=0, m_hi=2^32-1 -> ovf[0]=1; start -> ovf[0]=0.
REQ-031 SHALL cover: start held in DONE -> sums cleared, RUN; start pulsed in RUN -> no effect.
